panel_sequencer: RTL and testbench

Executes the debounced front-panel switch commands. Each command is acted on once per press, in priority order, and only while the CPU is halted. The block sits between the front-panel debouncer and the CPU/memory. It owns the panel address register, the instruction and data fields, and the memory-buffer display register. It borrows the memory port with a req/ack handshake for DEP and EXAM, and signals the CPU for CLEAR and CONT.

---
 rtl/panel_sequencer_pkg.sv | 36 +++
 rtl/panel_sequencer_edge_detect.sv | 21 ++
 rtl/panel_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_panel_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/panel_sequencer_pkg.sv
// Shared encodings for the front-panel command sequencer.
// State encodings, one-hot command bit order, and the priority selector.
// No timing of its own; consumed by panel_sequencer.
package panel_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_MEM     = 3'd2,
    ST_INCR    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // One-hot command vector, highest bit has highest priority.
  localparam int CMD_W     = 6;
  localparam int CMD_CLEAR = 5;
  localparam int CMD_EXTD  = 4;
  localparam int CMD_ALOAD = 3;
  localparam int CMD_DEP   = 2;
  localparam int CMD_EXAM  = 1;
  localparam int CMD_CONT  = 0;

  // Reduce the raw command lines to one-hot; later (higher) bits overwrite lower ones.
  function automatic logic [CMD_W-1:0] cmd_onehot(input logic [CMD_W-1:0] raw);
    logic [CMD_W-1:0] sel;
    sel = '0;
    for (int b = 0; b < CMD_W; b++) begin
      if (raw[b]) begin
        sel    = '0;
        sel[b] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/panel_sequencer_edge_detect.sv
// Rising-edge detector for the debounced panel strobe.
// Latency: combinational pulse in the first cycle the input is high.
// No backpressure; a held input yields a single one-cycle pulse.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  // One-cycle delayed copy of the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sig_d <= 1'b0;
    else       r_sig_d <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/panel_sequencer.sv
// Executes debounced front-panel commands (CLEAR/EXTD/ALOAD/DEP/EXAM/CONT) while the CPU is halted.
// Latency: effects visible 2 cycles after the strobe edge; DEP/EXAM add wait states until mem_ack.
// Backpressure: mem_req held until mem_ack; a held strobe is consumed once and never re-triggers.
module panel_sequencer
  import panel_sequencer_pkg::*;
#(
  parameter logic [11:0] start_addr = 12'o0200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        triggerd,
  input  logic        cleard,
  input  logic        extd_addrd,
  input  logic        addr_loadd,
  input  logic        depd,
  input  logic        examd,
  input  logic        contd,
  input  logic        sing_step,
  input  logic        cpu_halted,
  input  logic [11:0] sr,
  input  logic [11:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic [11:0] pc,
  output logic [2:0]  if_field,
  output logic [2:0]  df_field,
  output logic [11:0] mb,
  output logic        cpu_clear,
  output logic        cpu_run,
  output logic        cpu_step,
  output logic        cmd_err,
  output logic        busy
);

  state_t           r_state, w_state_nxt;
  logic [CMD_W-1:0] r_cmd, w_cmd_nxt;
  logic [11:0]      r_sr, w_sr_nxt;
  logic [11:0]      r_pc, w_pc_nxt;
  logic [2:0]       r_if, w_if_nxt;
  logic [2:0]       r_df, w_df_nxt;
  logic [11:0]      r_mb, w_mb_nxt;
  logic             r_mem_req, w_mem_req_nxt;
  logic             r_mem_we, w_mem_we_nxt;
  logic             r_clear, w_clear_nxt;
  logic             r_run, w_run_nxt;
  logic             r_step, w_step_nxt;
  logic             r_err, w_err_nxt;

  logic             w_trig_rise;
  logic [CMD_W-1:0] w_cmd_sel;

  edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_sig  (triggerd),
    .o_rise (w_trig_rise)
  );

  assign w_cmd_sel = cmd_onehot({cleard, extd_addrd, addr_loadd, depd, examd, contd});

  // State and all architectural registers; reset also drops mem_req asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_sr      <= '0;
      r_pc      <= start_addr;
      r_if      <= '0;
      r_df      <= '0;
      r_mb      <= '0;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_clear   <= 1'b0;
      r_run     <= 1'b0;
      r_step    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_cmd_nxt;
      r_sr      <= w_sr_nxt;
      r_pc      <= w_pc_nxt;
      r_if      <= w_if_nxt;
      r_df      <= w_df_nxt;
      r_mb      <= w_mb_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_clear   <= w_clear_nxt;
      r_run     <= w_run_nxt;
      r_step    <= w_step_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state and next register values; pulses default low, everything else holds.
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = r_cmd;
    w_sr_nxt      = r_sr;
    w_pc_nxt      = r_pc;
    w_if_nxt      = r_if;
    w_df_nxt      = r_df;
    w_mb_nxt      = r_mb;
    w_mem_req_nxt = r_mem_req;
    w_mem_we_nxt  = r_mem_we;
    w_clear_nxt   = 1'b0;
    w_run_nxt     = 1'b0;
    w_step_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_trig_rise) begin
          if (|w_cmd_sel) begin
            w_cmd_nxt   = w_cmd_sel;
            w_sr_nxt    = sr;
            w_state_nxt = ST_EXEC;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end
      end

      ST_EXEC: begin
        w_state_nxt = ST_RELEASE;
        if (!cpu_halted) begin
          w_err_nxt = 1'b1;
        end else if (r_cmd[CMD_CLEAR]) begin
          w_clear_nxt = 1'b1;
          w_mb_nxt    = '0;
        end else if (r_cmd[CMD_EXTD]) begin
          w_if_nxt = r_sr[5:3];
          w_df_nxt = r_sr[2:0];
        end else if (r_cmd[CMD_ALOAD]) begin
          w_pc_nxt = r_sr;
        end else if (r_cmd[CMD_DEP] || r_cmd[CMD_EXAM]) begin
          w_mem_req_nxt = 1'b1;
          w_mem_we_nxt  = r_cmd[CMD_DEP];
          w_state_nxt   = ST_MEM;
        end else if (r_cmd[CMD_CONT]) begin
          w_step_nxt = sing_step;
          w_run_nxt  = ~sing_step;
        end
      end

      // Transfer runs to completion even if the CPU leaves halt meanwhile.
      ST_MEM: begin
        if (mem_ack) begin
          w_mb_nxt      = r_cmd[CMD_DEP] ? r_sr : mem_rdata;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_state_nxt   = ST_INCR;
        end
      end

      ST_INCR: begin
        w_pc_nxt    = r_pc + 12'd1;
        w_state_nxt = ST_RELEASE;
      end

      ST_RELEASE: begin
        if (!triggerd) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = {r_if, r_pc};
  assign mem_wdata = r_sr;
  assign pc        = r_pc;
  assign if_field  = r_if;
  assign df_field  = r_df;
  assign mb        = r_mb;
  assign cpu_clear = r_clear;
  assign cpu_run   = r_run;
  assign cpu_step  = r_step;
  assign cmd_err   = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_panel_sequencer.sv
// Bench for panel_sequencer: table of panel presses with expected results, plus
// hand sequences for stray acks and reset during a memory transfer.
module tb_panel_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        triggerd, cleard, extd_addrd, addr_loadd, depd, examd, contd;
  logic        sing_step, cpu_halted;
  logic [11:0] sr, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata, pc, mb;
  logic [2:0]  if_field, df_field;
  logic        cpu_clear, cpu_run, cpu_step, cmd_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  panel_sequencer #(.start_addr(12'o0200)) dut (
    .clk(clk), .reset(reset), .triggerd(triggerd), .cleard(cleard),
    .extd_addrd(extd_addrd), .addr_loadd(addr_loadd), .depd(depd), .examd(examd),
    .contd(contd), .sing_step(sing_step), .cpu_halted(cpu_halted), .sr(sr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pc(pc), .if_field(if_field),
    .df_field(df_field), .mb(mb), .cpu_clear(cpu_clear), .cpu_run(cpu_run),
    .cpu_step(cpu_step), .cmd_err(cmd_err), .busy(busy)
  );

  typedef struct {
    logic [5:0]  cmd;      // {clear, extd, aload, dep, exam, cont}
    logic [11:0] sr;
    logic        halted, step, drop_halt;
    int          ack_dly;  // request cycles before the ack cycle
    int          hold;     // cycles triggerd stays high
    logic [11:0] rdata;
    logic [11:0] e_pc;
    logic [2:0]  e_if, e_df;
    logic [11:0] e_mb;
    int          e_clear, e_run, e_step, e_err, e_txn;
    logic [14:0] e_addr;
    logic        e_we;
    logic [11:0] e_wdata;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[13];

  localparam logic [5:0] C_CLEAR = 6'b100000, C_EXTD = 6'b010000, C_ALOAD = 6'b001000;
  localparam logic [5:0] C_DEP = 6'b000100, C_EXAM = 6'b000010, C_CONT = 6'b000001;

  function automatic vec_t mk(input logic [5:0] cmd, input logic [11:0] sr_v,
                              input logic h, input logic st, input logic dh,
                              input int ad, input int hd, input logic [11:0] rd,
                              input logic [11:0] pc_e, input logic [2:0] if_e,
                              input logic [2:0] df_e, input logic [11:0] mb_e,
                              input int c, input int r, input int s, input int er,
                              input int tx, input logic [14:0] ad_e, input logic we_e,
                              input logic [11:0] wd_e);
    vec_t v;
    v.cmd = cmd; v.sr = sr_v; v.halted = h; v.step = st; v.drop_halt = dh;
    v.ack_dly = ad; v.hold = hd; v.rdata = rd;
    v.e_pc = pc_e; v.e_if = if_e; v.e_df = df_e; v.e_mb = mb_e;
    v.e_clear = c; v.e_run = r; v.e_step = s; v.e_err = er; v.e_txn = tx;
    v.e_addr = ad_e; v.e_we = we_e; v.e_wdata = wd_e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o (octal) expected %0o (octal)", nm, act, exp);
    end
  endtask

  task automatic set_cmd(input logic [5:0] c);
    {cleard, extd_addrd, addr_loadd, depd, examd, contd} = c;
  endtask

  // Apply one press, act as the memory, count pulses, then pop and compare.
  task automatic run_vec(input int idx, input vec_t v);
    vec_t        e;
    int          n_clear = 0, n_run = 0, n_step = 0, n_err = 0, n_txn = 0, n_req = 0;
    int          t_req = -1, t_ack = -1, t_pc = -1, t_mb = -1, t_pulse = -1;
    int          req_seen = 0, i = 0;
    bit          acked = 0, done = 0, prev_req = 0;
    logic [11:0] pc0, mb0;
    logic [14:0] a_addr = '0;
    logic        a_we = 1'b0;
    logic [11:0] a_wd = '0;
    string       p;
    exp_q.push_back(v);
    @(negedge clk);
    pc0 = pc; mb0 = mb;
    set_cmd(v.cmd); sr = v.sr; cpu_halted = v.halted; sing_step = v.step;
    triggerd = 1'b1;
    while (!done && i < 300) begin
      @(negedge clk);
      i++;
      if (cpu_clear) n_clear++;
      if (cpu_run)   n_run++;
      if (cpu_step)  n_step++;
      if (cmd_err)   n_err++;
      if ((cpu_clear | cpu_run | cpu_step | cmd_err) && t_pulse < 0) t_pulse = i;
      if (mem_req && !prev_req) n_txn++;
      if (mem_req) n_req++;
      if (mem_req && t_req < 0) begin
        t_req = i;
        if (v.drop_halt) cpu_halted = 1'b0;
      end
      prev_req = mem_req;
      if (pc != pc0 && t_pc < 0) t_pc = i;
      if (mb != mb0 && t_mb < 0) t_mb = i;
      if (mem_ack) begin
        mem_ack = 1'b0;
        acked   = 1;
      end else if (mem_req && !acked) begin
        req_seen++;
        if (req_seen == v.ack_dly + 1) begin
          mem_ack = 1'b1; mem_rdata = v.rdata; t_ack = i;
          a_addr = mem_addr; a_we = mem_we; a_wd = mem_wdata;
        end
      end
      if (i == v.hold) begin
        triggerd = 1'b0;
        set_cmd(6'b0);
      end
      if (i > v.hold && !busy) done = 1;
    end
    p = $sformatf("v%0d", idx);
    check({p, " completion before timeout"}, done, 1);
    e = exp_q.pop_front();
    check({p, " pc"}, pc, e.e_pc);
    check({p, " if_field"}, if_field, e.e_if);
    check({p, " df_field"}, df_field, e.e_df);
    check({p, " mb"}, mb, e.e_mb);
    check({p, " cpu_clear pulses"}, n_clear, e.e_clear);
    check({p, " cpu_run pulses"}, n_run, e.e_run);
    check({p, " cpu_step pulses"}, n_step, e.e_step);
    check({p, " cmd_err pulses"}, n_err, e.e_err);
    check({p, " mem transactions"}, n_txn, e.e_txn);
    if (e.e_clear + e.e_run + e.e_step + e.e_err > 0)
      check({p, " pulse cycle"}, t_pulse, 2);
    if (e.e_txn > 0) begin
      check({p, " mem_addr"}, a_addr, e.e_addr);
      check({p, " mem_we"}, a_we, e.e_we);
      if (e.e_we) check({p, " mem_wdata"}, a_wd, e.e_wdata);
      check({p, " first req cycle"}, t_req, 2);
      check({p, " req cycles"}, n_req, v.ack_dly + 1);
      check({p, " pc update cycle"}, t_pc, t_ack + 2);
      if (e.e_mb != mb0) check({p, " mb update cycle"}, t_mb, t_ack + 1);
    end
  endtask

  initial begin
    bit got;
    reset = 1'b1; triggerd = 1'b0; set_cmd(6'b0); sing_step = 1'b0;
    cpu_halted = 1'b1; sr = '0; mem_rdata = '0; mem_ack = 1'b0;

    //        cmd              sr       h  st dh ad hd rdata    pc       if df mb       cl ru sp er tx addr       we wdata
    tbl[0]  = mk(C_ALOAD,        12'o1234, 1, 0, 0, 0, 4, 12'o0,   12'o1234, 0, 0, 12'o0,    0, 0, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[1]  = mk(C_DEP,          12'o7070, 1, 0, 0, 0, 4, 12'o0,   12'o1235, 0, 0, 12'o7070, 0, 0, 0, 0, 1, 15'o01234, 1, 12'o7070);
    tbl[2]  = mk(C_ALOAD,        12'o7777, 1, 0, 0, 0, 4, 12'o0,   12'o7777, 0, 0, 12'o7070, 0, 0, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[3]  = mk(C_EXTD,         12'o0030, 1, 0, 0, 0, 4, 12'o0,   12'o7777, 3, 0, 12'o7070, 0, 0, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[4]  = mk(C_EXAM,         12'o0000, 1, 0, 0, 5, 4, 12'o0456, 12'o0000, 3, 0, 12'o0456, 0, 0, 0, 0, 1, 15'o37777, 0, 12'o0);
    tbl[5]  = mk(C_DEP | C_EXTD, 12'o0052, 1, 0, 0, 0, 4, 12'o0,   12'o0000, 5, 2, 12'o0456, 0, 0, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[6]  = mk(C_ALOAD,        12'o4444, 0, 0, 0, 0, 4, 12'o0,   12'o0000, 5, 2, 12'o0456, 0, 0, 0, 1, 0, 15'o0,     0, 12'o0);
    tbl[7]  = mk(C_CONT,         12'o0000, 1, 1, 0, 0, 20, 12'o0,  12'o0000, 5, 2, 12'o0456, 0, 0, 1, 0, 0, 15'o0,     0, 12'o0);
    tbl[8]  = mk(C_CONT,         12'o0000, 1, 0, 0, 0, 4, 12'o0,   12'o0000, 5, 2, 12'o0456, 0, 1, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[9]  = mk(C_CLEAR,        12'o0000, 1, 0, 0, 0, 4, 12'o0,   12'o0000, 5, 2, 12'o0000, 1, 0, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[10] = mk(C_DEP,          12'o2222, 0, 0, 0, 0, 4, 12'o0,   12'o0000, 5, 2, 12'o0000, 0, 0, 0, 1, 0, 15'o0,     0, 12'o0);
    tbl[11] = mk(6'b000000,      12'o3333, 1, 0, 0, 0, 4, 12'o0,   12'o0000, 5, 2, 12'o0000, 0, 0, 0, 0, 0, 15'o0,     0, 12'o0);
    tbl[12] = mk(C_EXAM,         12'o0000, 1, 0, 1, 2, 4, 12'o1111, 12'o0001, 5, 2, 12'o1111, 0, 0, 0, 0, 1, 15'o50000, 0, 12'o0);

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset pc", pc, 12'o0200);
    check("reset if_field", if_field, 0);
    check("reset df_field", df_field, 0);
    check("reset mb", mb, 0);
    check("reset mem_req", mem_req, 0);
    check("reset busy", busy, 0);
    check("reset pulses", {cpu_clear, cpu_run, cpu_step, cmd_err}, 0);
    reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      run_vec(k, tbl[k]);
      if (k == 8) begin
        // A stray ack while idle must not touch mb or pc.
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 12'o7777;
        @(negedge clk); mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("stray ack mb", mb, 12'o0456);
        check("stray ack pc", pc, 12'o0000);
        check("stray ack busy", busy, 0);
      end
    end

    // Reset in the middle of an EXAM that never gets acked.
    @(negedge clk);
    set_cmd(C_EXAM); cpu_halted = 1'b1; triggerd = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    check("mid-mem req seen", got, 1);
    #2 reset = 1'b1;
    #1 check("mid-mem reset drops mem_req", mem_req, 0);
    check("mid-mem reset busy", busy, 0);
    @(negedge clk);
    reset = 1'b0; triggerd = 1'b0; set_cmd(6'b0);
    repeat (3) @(negedge clk);
    check("post-reset pc", pc, 12'o0200);
    check("post-reset mb", mb, 0);
    check("post-reset if_field", if_field, 0);
    check("post-reset mem_req", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
